// File: rtl/c7bbiu_rd_arb.sv
// Read-channel arbiter sharing one downstream bus read port between icu and lsu.
// Ownership is held from grant through the final data beat.
module c7bbiu_rd_arb #(
  parameter int LINE_BEATS = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        icu_biu_req,
  input  logic [31:3] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  input  logic        lsu_biu_rd_req,
  input  logic [31:3] lsu_biu_rd_addr,
  input  logic        lsu_biu_rd_single,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_data_valid,
  output logic        biu_lsu_data_last,
  output logic [63:0] biu_lsu_data,
  output logic        biu_lsu_fault,
  output logic        arb_bus_req,
  output logic [31:3] arb_bus_addr,
  output logic        arb_bus_single,
  input  logic        bus_arb_ack,
  input  logic        bus_arb_data_valid,
  input  logic        bus_arb_data_last,
  input  logic [63:0] bus_arb_data,
  input  logic        bus_arb_fault,
  output logic        arb_proto_err
);

  localparam int CW = $clog2(LINE_BEATS) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic OWN_ICU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW:0]   EXP_ONE  = (CW+1)'(1);
  localparam logic [CW:0]   EXP_LINE = (CW+1)'(LINE_BEATS);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          single_q, single_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_lsu;
  logic          in_req, in_data;
  logic          ack_fire, beat, icu_beat, lsu_beat;
  logic [CW:0]   cnt_inc, cnt_exp;

  // A tie goes to icu under fixed priority, otherwise to whoever was not served last.
  always_comb begin
    pick_lsu = lsu_biu_rd_req;
    if (icu_biu_req && lsu_biu_rd_req) begin
      pick_lsu = FIXED_PRIO ? 1'b0 : (last_grant_q == OWN_ICU);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    single_d     = single_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (icu_biu_req || lsu_biu_rd_req) begin
          state_d  = ST_REQ;
          owner_d  = pick_lsu ? OWN_LSU : OWN_ICU;
          single_d = pick_lsu ? lsu_biu_rd_single : icu_biu_single;
        end
      end
      ST_REQ: begin
        if (bus_arb_ack) begin
          state_d      = ST_DATA;
          last_grant_d = owner_q;
          cnt_d        = '0;
        end
      end
      ST_DATA: begin
        if (bus_arb_data_valid) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (bus_arb_data_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_ICU;
      last_grant_q <= OWN_LSU;
      single_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      single_q     <= single_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_req   = (state_q == ST_REQ);
  assign in_data  = (state_q == ST_DATA);
  assign ack_fire = in_req & bus_arb_ack;
  assign beat     = in_data & bus_arb_data_valid;
  assign icu_beat = beat & (owner_q == OWN_ICU);
  assign lsu_beat = beat & (owner_q == OWN_LSU);

  // Address/single follow the owner's live inputs and read as zero outside REQ.
  assign arb_bus_req    = in_req;
  assign arb_bus_addr   = !in_req ? '0 :
                          (owner_q == OWN_LSU) ? lsu_biu_rd_addr : icu_biu_addr;
  assign arb_bus_single = in_req &
                          ((owner_q == OWN_LSU) ? lsu_biu_rd_single : icu_biu_single);

  assign biu_icu_ack    = ack_fire & (owner_q == OWN_ICU);
  assign biu_lsu_rd_ack = ack_fire & (owner_q == OWN_LSU);

  assign biu_icu_data_valid = icu_beat;
  assign biu_icu_data_last  = icu_beat & bus_arb_data_last;
  assign biu_icu_fault      = icu_beat & bus_arb_fault;
  assign biu_icu_data       = icu_beat ? bus_arb_data : '0;

  assign biu_lsu_data_valid = lsu_beat;
  assign biu_lsu_data_last  = lsu_beat & bus_arb_data_last;
  assign biu_lsu_fault      = lsu_beat & bus_arb_fault;
  assign biu_lsu_data       = lsu_beat ? bus_arb_data : '0;

  // The final beat must land exactly on the expected burst length.
  assign cnt_inc       = {1'b0, cnt_q} + EXP_ONE;
  assign cnt_exp       = single_q ? EXP_ONE : EXP_LINE;
  assign arb_proto_err = beat & bus_arb_data_last & (cnt_inc != cnt_exp);

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Directed bench for c7bbiu_rd_arb: one round-robin instance and one fixed-priority
// instance share the stimulus.
module tb_c7bbiu_rd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        icu_req, icu_single, lsu_req, lsu_single;
  logic [31:3] icu_addr, lsu_addr;
  logic        bus_ack, bus_valid, bus_last, bus_fault;
  logic [63:0] bus_data;

  logic        icu_ack, icu_vld, icu_last, icu_fault;
  logic [63:0] icu_data;
  logic        lsu_ack, lsu_vld, lsu_last, lsu_fault;
  logic [63:0] lsu_data;
  logic        bus_req, bus_single, proto_err;
  logic [31:3] bus_addr;

  logic        icu_ack_f, icu_vld_f, icu_last_f, icu_fault_f;
  logic [63:0] icu_data_f;
  logic        lsu_ack_f, lsu_vld_f, lsu_last_f, lsu_fault_f;
  logic [63:0] lsu_data_f;
  logic        bus_req_f, bus_single_f, proto_err_f;
  logic [31:3] bus_addr_f;

  int n_tests = 0;
  int n_fail  = 0;

  c7bbiu_rd_arb #(.LINE_BEATS(4), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .icu_biu_req(icu_req), .icu_biu_addr(icu_addr), .icu_biu_single(icu_single),
    .biu_icu_ack(icu_ack), .biu_icu_data_valid(icu_vld), .biu_icu_data_last(icu_last),
    .biu_icu_data(icu_data), .biu_icu_fault(icu_fault),
    .lsu_biu_rd_req(lsu_req), .lsu_biu_rd_addr(lsu_addr), .lsu_biu_rd_single(lsu_single),
    .biu_lsu_rd_ack(lsu_ack), .biu_lsu_data_valid(lsu_vld), .biu_lsu_data_last(lsu_last),
    .biu_lsu_data(lsu_data), .biu_lsu_fault(lsu_fault),
    .arb_bus_req(bus_req), .arb_bus_addr(bus_addr), .arb_bus_single(bus_single),
    .bus_arb_ack(bus_ack), .bus_arb_data_valid(bus_valid), .bus_arb_data_last(bus_last),
    .bus_arb_data(bus_data), .bus_arb_fault(bus_fault),
    .arb_proto_err(proto_err)
  );

  c7bbiu_rd_arb #(.LINE_BEATS(4), .FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .resetn(resetn),
    .icu_biu_req(icu_req), .icu_biu_addr(icu_addr), .icu_biu_single(icu_single),
    .biu_icu_ack(icu_ack_f), .biu_icu_data_valid(icu_vld_f), .biu_icu_data_last(icu_last_f),
    .biu_icu_data(icu_data_f), .biu_icu_fault(icu_fault_f),
    .lsu_biu_rd_req(lsu_req), .lsu_biu_rd_addr(lsu_addr), .lsu_biu_rd_single(lsu_single),
    .biu_lsu_rd_ack(lsu_ack_f), .biu_lsu_data_valid(lsu_vld_f), .biu_lsu_data_last(lsu_last_f),
    .biu_lsu_data(lsu_data_f), .biu_lsu_fault(lsu_fault_f),
    .arb_bus_req(bus_req_f), .arb_bus_addr(bus_addr_f), .arb_bus_single(bus_single_f),
    .bus_arb_ack(bus_ack), .bus_arb_data_valid(bus_valid), .bus_arb_data_last(bus_last),
    .bus_arb_data(bus_data), .bus_arb_fault(bus_fault),
    .arb_proto_err(proto_err_f)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    icu_req = 0; icu_addr = '0; icu_single = 0;
    lsu_req = 0; lsu_addr = '0; lsu_single = 0;
    bus_ack = 0; bus_valid = 0; bus_last = 0; bus_fault = 0; bus_data = '0;
  endtask

  task do_reset;
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task test_reset;
    resetn = 1'b0;
    clear_inputs();
    icu_req = 1; icu_addr = 29'h1234; bus_valid = 1; bus_data = 64'hDEAD; bus_ack = 1;
    step();
    @(negedge clk);
    n_tests++;
    if ({bus_req, icu_ack, lsu_ack, icu_vld, lsu_vld, icu_last, lsu_last, proto_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {bus_req, icu_ack, lsu_ack, icu_vld, lsu_vld, icu_last, lsu_last, proto_err});
    end
    n_tests++;
    if ({bus_addr, bus_single, icu_data, lsu_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data addr %h data %h/%h want 0", bus_addr, icu_data, lsu_data);
    end
    do_reset();
  endtask

  task test_icu_linefill;
    logic [63:0] d;
    do_reset();
    icu_req = 1; icu_addr = 29'h200; icu_single = 0;
    @(negedge clk);
    n_tests++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL lf_idle_req got %b want 0", bus_req);
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({bus_req, bus_addr, bus_single} !== {1'b1, 29'h200, 1'b0}) begin
      n_fail++; $display("FAIL lf_req got %b/%h/%b want 1/200/0", bus_req, bus_addr, bus_single);
    end
    step();
    bus_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_req, icu_ack, lsu_ack} !== 3'b110) begin
      n_fail++; $display("FAIL lf_ack got %b want 110", {bus_req, icu_ack, lsu_ack});
    end
    step();
    bus_ack = 0; icu_req = 0;
    for (int i = 0; i < 4; i++) begin
      d = 64'hD000_0000_0000_0000 | 64'(i);
      bus_valid = 1; bus_data = d; bus_last = (i == 3);
      @(negedge clk);
      n_tests++;
      if ({icu_vld, icu_last, icu_data} !== {1'b1, logic'(i == 3), d}) begin
        n_fail++;
        $display("FAIL lf_beat%0d got %b/%b/%h want 1/%b/%h", i, icu_vld, icu_last, icu_data, (i == 3), d);
      end
      n_tests++;
      if ({lsu_vld, lsu_last, lsu_fault, lsu_data, proto_err, bus_req} !== '0) begin
        n_fail++;
        $display("FAIL lf_quiet%0d lsu %b/%b/%h err %b req %b want 0", i, lsu_vld, lsu_last, lsu_data, proto_err, bus_req);
      end
      step();
    end
    bus_valid = 0; bus_last = 0;
    @(negedge clk);
    n_tests++;
    if ({bus_req, icu_vld} !== 2'b00) begin
      n_fail++; $display("FAIL lf_done got %b want 00", {bus_req, icu_vld});
    end
  endtask

  task test_round_robin;
    logic [63:0] d;
    do_reset();
    icu_req = 1; icu_addr = 29'h0AA; icu_single = 0;
    lsu_req = 1; lsu_addr = 29'h155; lsu_single = 1;
    step();
    bus_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_addr, bus_single, icu_ack, lsu_ack} !== {29'h0AA, 1'b0, 2'b10}) begin
      n_fail++; $display("FAIL rr_first got %h/%b/%b%b want 0aa/0/10", bus_addr, bus_single, icu_ack, lsu_ack);
    end
    step();
    bus_ack = 0; icu_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus_valid = 1; bus_data = 64'(100 + i); bus_last = (i == 3);
      @(negedge clk);
      n_tests++;
      if ({icu_vld, lsu_vld, lsu_ack} !== 3'b100) begin
        n_fail++; $display("FAIL rr_icu_beat%0d got %b want 100", i, {icu_vld, lsu_vld, lsu_ack});
      end
      step();
    end
    bus_valid = 0; bus_last = 0; icu_req = 1;
    @(negedge clk);
    n_tests++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_gap got %b want 0", bus_req);
    end
    step();
    bus_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_addr, bus_single, icu_ack, lsu_ack} !== {29'h155, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL rr_second got %h/%b/%b%b want 155/1/01", bus_addr, bus_single, icu_ack, lsu_ack);
    end
    step();
    bus_ack = 0; lsu_req = 0;
    d = 64'h5151_0000_CAFE_0001;
    bus_valid = 1; bus_last = 1; bus_data = d;
    @(negedge clk);
    n_tests++;
    if ({lsu_vld, lsu_last, lsu_data, icu_vld, proto_err} !== {2'b11, d, 2'b00}) begin
      n_fail++; $display("FAIL rr_lsu_beat got %b/%b/%h icu %b err %b", lsu_vld, lsu_last, lsu_data, icu_vld, proto_err);
    end
    step();
    bus_valid = 0; bus_last = 0; lsu_req = 1;
    step();
    bus_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_addr, icu_ack, lsu_ack} !== {29'h0AA, 2'b10}) begin
      n_fail++; $display("FAIL rr_third got %h/%b%b want 0aa/10", bus_addr, icu_ack, lsu_ack);
    end
    step();
    bus_ack = 0;
  endtask

  task test_fixed_prio;
    do_reset();
    icu_req = 1; icu_addr = 29'h0AA; icu_single = 1;
    lsu_req = 1; lsu_addr = 29'h155; lsu_single = 1;
    for (int r = 0; r < 3; r++) begin
      step();
      bus_ack = 1;
      @(negedge clk);
      n_tests++;
      if ({bus_req_f, bus_addr_f, icu_ack_f, lsu_ack_f} !== {1'b1, 29'h0AA, 2'b10}) begin
        n_fail++; $display("FAIL fp_grant%0d got %b/%h/%b%b want 1/0aa/10", r, bus_req_f, bus_addr_f, icu_ack_f, lsu_ack_f);
      end
      step();
      bus_ack = 0; bus_valid = 1; bus_last = 1;
      @(negedge clk);
      n_tests++;
      if ({icu_vld_f, lsu_vld_f, proto_err_f} !== 3'b100) begin
        n_fail++; $display("FAIL fp_beat%0d got %b want 100", r, {icu_vld_f, lsu_vld_f, proto_err_f});
      end
      step();
      bus_valid = 0; bus_last = 0;
      @(negedge clk);
      n_tests++;
      if ({bus_req_f, lsu_ack_f} !== 2'b00) begin
        n_fail++; $display("FAIL fp_idle%0d got %b want 00", r, {bus_req_f, lsu_ack_f});
      end
    end
  endtask

  task test_early_last;
    do_reset();
    icu_req = 1; icu_addr = 29'h300; icu_single = 0;
    step();
    bus_ack = 1;
    step();
    bus_ack = 0; icu_req = 0; bus_valid = 1; bus_last = 0; bus_data = 64'd1;
    @(negedge clk);
    n_tests++;
    if ({icu_vld, proto_err} !== 2'b10) begin
      n_fail++; $display("FAIL el_beat0 got %b want 10", {icu_vld, proto_err});
    end
    step();
    bus_last = 1; bus_data = 64'd2;
    @(negedge clk);
    n_tests++;
    if ({icu_vld, icu_last, proto_err} !== 3'b111) begin
      n_fail++; $display("FAIL el_err got %b want 111", {icu_vld, icu_last, proto_err});
    end
    step();
    bus_valid = 0; bus_last = 0;
    lsu_req = 1; lsu_addr = 29'h0F0; lsu_single = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_req, proto_err} !== 2'b00) begin
      n_fail++; $display("FAIL el_after got %b want 00", {bus_req, proto_err});
    end
    step();
    bus_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_req, bus_addr, lsu_ack} !== {1'b1, 29'h0F0, 1'b1}) begin
      n_fail++; $display("FAIL el_regrant got %b/%h/%b want 1/0f0/1", bus_req, bus_addr, lsu_ack);
    end
    step();
    bus_ack = 0; lsu_req = 0; bus_valid = 1; bus_last = 1;
    @(negedge clk);
    n_tests++;
    if ({lsu_vld, lsu_last, proto_err} !== 3'b110) begin
      n_fail++; $display("FAIL el_single got %b want 110", {lsu_vld, lsu_last, proto_err});
    end
    step();
    bus_valid = 0; bus_last = 0;
  endtask

  task test_lsu_fault;
    do_reset();
    lsu_req = 1; lsu_addr = 29'h0F0; lsu_single = 1;
    step();
    bus_ack = 1;
    step();
    bus_ack = 0; lsu_req = 0;
    bus_valid = 1; bus_last = 1; bus_fault = 1; bus_data = 64'hFA17;
    @(negedge clk);
    n_tests++;
    if ({lsu_vld, lsu_last, lsu_fault, lsu_data} !== {3'b111, 64'hFA17}) begin
      n_fail++; $display("FAIL flt_lsu got %b/%b/%b/%h want 1/1/1/fa17", lsu_vld, lsu_last, lsu_fault, lsu_data);
    end
    n_tests++;
    if ({icu_vld, icu_last, icu_fault, icu_data, proto_err} !== '0) begin
      n_fail++; $display("FAIL flt_icu got %b/%b/%b/%h err %b want 0", icu_vld, icu_last, icu_fault, icu_data, proto_err);
    end
    step();
    bus_valid = 0; bus_last = 0; bus_fault = 0;
  endtask

  task test_reset_mid;
    do_reset();
    icu_req = 1; icu_addr = 29'h400; icu_single = 0;
    step();
    bus_ack = 1;
    step();
    bus_ack = 0; icu_req = 0; bus_valid = 1; bus_data = 64'd10;
    @(negedge clk);
    n_tests++;
    if (icu_vld !== 1'b1) begin
      n_fail++; $display("FAIL rm_beat0 got %b want 1", icu_vld);
    end
    step();
    bus_data = 64'd11; resetn = 0;
    @(negedge clk);
    n_tests++;
    if ({icu_vld, lsu_vld, icu_data, bus_req, proto_err} !== '0) begin
      n_fail++; $display("FAIL rm_during got %b/%b/%h want 0", icu_vld, lsu_vld, icu_data);
    end
    step();
    resetn = 1; bus_data = 64'd12;
    @(negedge clk);
    n_tests++;
    if ({icu_vld, lsu_vld, icu_data} !== '0) begin
      n_fail++; $display("FAIL rm_after got %b/%b/%h want 0", icu_vld, lsu_vld, icu_data);
    end
    step();
    bus_data = 64'd13; bus_last = 1;
    @(negedge clk);
    n_tests++;
    if ({icu_vld, icu_last, lsu_vld, proto_err, bus_req} !== 5'b0) begin
      n_fail++; $display("FAIL rm_last got %b want 00000", {icu_vld, icu_last, lsu_vld, proto_err, bus_req});
    end
    step();
    bus_valid = 0; bus_last = 0; icu_req = 1; icu_addr = 29'h500;
    @(negedge clk);
    n_tests++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL rm_idle got %b want 0", bus_req);
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({bus_req, bus_addr} !== {1'b1, 29'h500}) begin
      n_fail++; $display("FAIL rm_regrant got %b/%h want 1/500", bus_req, bus_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_icu_linefill();
    test_round_robin();
    test_fixed_prio();
    test_early_last();
    test_lsu_fault();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
